inst_fetch: RTL and testbench

- IF stage directly upstream of instruction decode.
- Generates the PC, translates it via the MMU port and issues one instruction-bus read at a time.
- Publishes the registered `pipe_if` record describing the in-flight fetch. ID qualifies that record with `ibus_valid`/`ibus_rddata` itself.
- Handles exception redirects, branch redirects with MIPS delay slot, and ID back-pressure.

---
 rtl/cpu_defs.sv | 47 ++++
 rtl/inst_fetch_pc_gen.sv | 48 ++++
 rtl/inst_fetch.sv | 126 ++++++++++++
 tb/tb_inst_fetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU front-end types: MMU request/response, redirect requests and the IF->ID record.
package cpu_defs;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'hbfc0_0000;
    localparam int unsigned N_ISSUE_MAX       = 32'd1;

    typedef logic [31:0] virt_t;
    typedef logic [31:0] phys_t;

    typedef struct packed {
        logic  valid;
        virt_t except_vec;
    } except_req_t;

    typedef struct packed {
        logic  valid;
        virt_t target;
    } branch_req_t;

    typedef struct packed {
        phys_t paddr;
        logic  illegal;
        logic  miss;
    } mmu_resp_t;

    typedef struct packed {
        virt_t vaddr;
        phys_t paddr;
        logic  illegal;
        logic  miss;
    } mmu_iaddr_resp_t;

    typedef struct packed {
        logic                                   valid;
        mmu_iaddr_resp_t [N_ISSUE_MAX-1:0]      mmu_iaddr_resp;
        logic                                   iaddr_ex;
    } pipe_if_t;

    typedef enum logic [2:0] {
        S_REQ     = 3'd0,
        S_WAIT    = 3'd1,
        S_HOLD    = 3'd2,
        S_DISCARD = 3'd3,
        S_EXWAIT  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_pc_gen.sv
// PC register with exception / delayed-branch / sequential next-PC selection.
module pc_gen
    import cpu_defs::*;
#(
    parameter virt_t RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  except_req_t except_req,
    input  branch_req_t branch_req,
    input  logic        advance,
    output virt_t       pc
);

    virt_t pc_r;
    virt_t target_r;
    logic  pending_r;

    // Next-PC: exception first, then branch redirect on the delay-slot fetch, else pc+4.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r      <= RESET_VEC;
            target_r  <= 32'h0000_0000;
            pending_r <= 1'b0;
        end else if (except_req.valid) begin
            pc_r      <= except_req.except_vec;
            pending_r <= 1'b0;
        end else if (advance) begin
            // A branch arriving with the delay-slot acceptance redirects immediately.
            if (branch_req.valid) begin
                pc_r <= branch_req.target;
            end else if (pending_r) begin
                pc_r <= target_r;
            end else begin
                pc_r <= pc_r + 32'd4;
            end
            pending_r <= 1'b0;
        end else if (branch_req.valid) begin
            pending_r <= 1'b1;
            target_r  <= branch_req.target;
        end else begin
            pending_r <= pending_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/inst_fetch.sv
// IF stage: one outstanding instruction-bus read, delayed branches, exception flush.
// Optional INST_FETCH_ADDR_CHECK_EN: misaligned / MMU-faulting PCs become faulting fetches.
module inst_fetch
    import cpu_defs::*;
#(
    parameter virt_t RESET_VEC = RESET_VEC_DEFAULT,
    parameter int    N_ISSUE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready_i,
    input  except_req_t except_req,
    input  branch_req_t branch_req,
    output virt_t       mmu_vaddr,
    input  mmu_resp_t   mmu_resp,
    output logic        ibus_read,
    output logic [31:0] ibus_addr,
    input  logic        ibus_addr_ok,
    input  logic        ibus_valid,
    output pipe_if_t    pipe_if
);

    generate
        if (N_ISSUE != 1) begin : g_bad_issue
            $error("inst_fetch: only N_ISSUE == 1 is supported");
        end
    endgenerate

    fetch_state_t    state_r;
    pipe_if_t        pipe_if_r;
    virt_t           pc_s;
    logic            addr_fault_s;
    logic            accept_s;
    logic            advance_s;
    mmu_iaddr_resp_t fetch_resp_s;

`ifdef INST_FETCH_ADDR_CHECK_EN
    assign addr_fault_s = (pc_s[1:0] != 2'b00) || mmu_resp.illegal || mmu_resp.miss;
`else
    assign addr_fault_s = 1'b0;
`endif

    assign mmu_vaddr = pc_s;
    assign ibus_addr = mmu_resp.paddr;
    assign ibus_read = rst && (state_r == S_REQ) && !addr_fault_s;
    assign accept_s  = ibus_read && ibus_addr_ok;
    assign advance_s = (state_r == S_REQ) && (accept_s || addr_fault_s);

    assign fetch_resp_s.vaddr   = pc_s;
    assign fetch_resp_s.paddr   = mmu_resp.paddr;
    assign fetch_resp_s.illegal = mmu_resp.illegal;
    assign fetch_resp_s.miss    = mmu_resp.miss;

    pc_gen #(
        .RESET_VEC (RESET_VEC)
    ) u_pc_gen (
        .clk        (clk),
        .rst        (rst),
        .except_req (except_req),
        .branch_req (branch_req),
        .advance    (advance_s),
        .pc         (pc_s)
    );

    // Fetch FSM and the registered record handed to ID.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= S_REQ;
            pipe_if_r <= '0;
        end else if (except_req.valid) begin
            pipe_if_r <= '0;
            // A read still in flight must have its data swallowed before refetching.
            case (state_r)
                S_REQ:     state_r <= accept_s   ? S_DISCARD : S_REQ;
                S_WAIT:    state_r <= ibus_valid ? S_REQ     : S_DISCARD;
                S_DISCARD: state_r <= ibus_valid ? S_REQ     : S_DISCARD;
                default:   state_r <= S_REQ;
            endcase
        end else begin
            case (state_r)
                S_REQ: begin
                    if (addr_fault_s) begin
                        pipe_if_r.valid             <= 1'b1;
                        pipe_if_r.mmu_iaddr_resp[0] <= fetch_resp_s;
                        pipe_if_r.iaddr_ex          <= 1'b1;
                        state_r                     <= S_EXWAIT;
                    end else if (accept_s) begin
                        pipe_if_r.valid             <= 1'b1;
                        pipe_if_r.mmu_iaddr_resp[0] <= fetch_resp_s;
                        pipe_if_r.iaddr_ex          <= 1'b0;
                        state_r                     <= S_WAIT;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (ibus_valid && ready_i) begin
                        pipe_if_r.valid <= 1'b0;
                        state_r         <= S_REQ;
                    end else if (ibus_valid) begin
                        state_r <= S_HOLD;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_HOLD, S_EXWAIT: begin
                    if (ready_i) begin
                        pipe_if_r.valid <= 1'b0;
                        state_r         <= S_REQ;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_DISCARD: begin
                    state_r <= ibus_valid ? S_REQ : S_DISCARD;
                end
                default: begin
                    state_r <= S_REQ;
                end
            endcase
        end
    end

    assign pipe_if = pipe_if_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed table, corner sequences, randomized run vs. a transaction-level model.
module tb_inst_fetch;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready_i;
    except_req_t except_req;
    branch_req_t branch_req;
    virt_t       mmu_vaddr;
    mmu_resp_t   mmu_resp;
    logic        ibus_read;
    logic [31:0] ibus_addr;
    logic        ibus_addr_ok;
    logic        ibus_valid;
    pipe_if_t    pipe_if;

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .ready_i      (ready_i),
        .except_req   (except_req),
        .branch_req   (branch_req),
        .mmu_vaddr    (mmu_vaddr),
        .mmu_resp     (mmu_resp),
        .ibus_read    (ibus_read),
        .ibus_addr    (ibus_addr),
        .ibus_addr_ok (ibus_addr_ok),
        .ibus_valid   (ibus_valid),
        .pipe_if      (pipe_if)
    );

    always #5 clk = ~clk;

    // kseg1-style MMU: strip the top three bits
    always_comb begin
        mmu_resp.paddr   = mmu_vaddr & 32'h1fff_ffff;
        mmu_resp.illegal = 1'b0;
        mmu_resp.miss    = 1'b0;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference: program-order next PC plus bus/ID occupancy.
    logic [31:0] m_pc, m_tgt, m_last;
    logic        m_pend, m_outst, m_flush, m_hold, m_lastex;
    logic [31:0] acc_q[$];

    logic        bus_busy;
    int          bus_cnt;

    function automatic logic [31:0] fmap(input logic [31:0] v);
        return v & 32'h1fff_ffff;
    endfunction

    function automatic logic m_fault(input logic [31:0] pc);
`ifdef INST_FETCH_ADDR_CHECK_EN
        return pc[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b0;
        ready_i      = 1'b0;
        ibus_addr_ok = 1'b0;
        ibus_valid   = 1'b0;
        except_req   = '0;
        branch_req   = '0;
        @(negedge clk);
        check1("rst_ibus_read", ibus_read, 1'b0);
        check1("rst_pipe_valid", pipe_if.valid, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        m_pc     = 32'hbfc0_0000;
        m_tgt    = 32'h0;
        m_last   = 32'h0;
        m_pend   = 1'b0;
        m_outst  = 1'b0;
        m_flush  = 1'b0;
        m_hold   = 1'b0;
        m_lastex = 1'b0;
        bus_busy = 1'b0;
        bus_cnt  = 0;
        acc_q.delete();
    endtask

    // Drive one cycle at the falling edge, check pre-edge outputs, advance the model.
    task automatic step(input logic ok, input logic iv, input logic rdy,
                        input logic brv, input logic [31:0] brt,
                        input logic exv, input logic [31:0] exvec,
                        output logic acc);
        logic flt, exp_read, exp_v, m_acc;
        @(negedge clk);
        ibus_addr_ok          = ok;
        ibus_valid            = iv;
        ready_i               = rdy;
        branch_req.valid      = brv;
        branch_req.target     = brt;
        except_req.valid      = exv;
        except_req.except_vec = exvec;
        #1;
        flt      = m_fault(m_pc);
        exp_read = !m_outst && !m_hold && !flt;
        exp_v    = (m_outst && !m_flush) || m_hold;
        check1("ibus_read", ibus_read, exp_read);
        check32("mmu_vaddr", mmu_vaddr, m_pc);
        if (exp_read) check32("ibus_addr", ibus_addr, fmap(m_pc));
        check1("pipe_valid", pipe_if.valid, exp_v);
        if (exp_v) begin
            check32("pipe_vaddr", pipe_if.mmu_iaddr_resp[0].vaddr, m_last);
            check1("pipe_iaddr_ex", pipe_if.iaddr_ex, m_lastex);
        end
        acc = ibus_read && ok;
        if (acc) acc_q.push_back(ibus_addr);
        m_acc = exp_read && ok;
        if (exv) begin
            if (m_acc) begin
                m_outst = 1'b1;
                m_flush = 1'b1;
            end else if (m_outst) begin
                if (iv) begin
                    m_outst = 1'b0;
                    m_flush = 1'b0;
                end else begin
                    m_flush = 1'b1;
                end
            end
            m_hold = 1'b0;
            m_pc   = exvec;
            m_pend = 1'b0;
        end else if (m_acc || (!m_outst && !m_hold && flt)) begin
            m_last   = m_pc;
            m_lastex = flt;
            if (flt) m_hold = 1'b1;
            else begin
                m_outst = 1'b1;
                m_flush = 1'b0;
            end
            if (brv)         m_pc = brt;
            else if (m_pend) m_pc = m_tgt;
            else             m_pc = m_pc + 32'd4;
            m_pend = 1'b0;
        end else begin
            if (brv) begin
                m_pend = 1'b1;
                m_tgt  = brt;
            end
            if (m_outst && iv) begin
                if (!m_flush && !rdy) m_hold = 1'b1;
                m_outst = 1'b0;
                m_flush = 1'b0;
            end else if (m_hold && rdy) begin
                m_hold = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic        ok, iv, rdy;
        logic        exp_read;
        logic [31:0] exp_addr;
        logic        exp_v;
        logic [31:0] exp_vaddr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic a;
        int   found;
        logic [31:0] vec;

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1fc0_0000, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hbfc0_0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1fc0_0004, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hbfc0_0004};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1fc0_0008, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hbfc0_0008};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hbfc0_0008};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hbfc0_0008};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hbfc0_0008};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1fc0_000c, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hbfc0_000c};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1fc0_0010, 1'b0, 32'h0};

        // Straight-line fetch with a three-cycle ID stall
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].ok, tbl[i].iv, tbl[i].rdy, 1'b0, 32'h0, 1'b0, 32'h0, a);
            check1("tbl_read", ibus_read, tbl[i].exp_read);
            if (tbl[i].exp_read) check32("tbl_addr", ibus_addr, tbl[i].exp_addr);
            check1("tbl_valid", pipe_if.valid, tbl[i].exp_v);
            if (tbl[i].exp_v) check32("tbl_vaddr", pipe_if.mmu_iaddr_resp[0].vaddr, tbl[i].exp_vaddr);
        end

        // Branch decoded while 0xbfc00004 is in WAIT: delay slot then target
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hbfc0_0100, 1'b0, 32'h0, a);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a);
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a);
        end
        check32("br_count", acc_q.size(), 32'd4);
        check32("br_delay_slot", acc_q[2], 32'h1fc0_0008);
        check32("br_target", acc_q[3], 32'h1fc0_0100);

        // Exception in WAIT; late response is dropped, refetch at vector
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hbfc0_0380, a);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a);
        check1("exc_drop_valid", pipe_if.valid, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a);
        check32("exc_count", acc_q.size(), 32'd2);
        check32("exc_refetch", acc_q[1], 32'h1fc0_0380);

        // Exception and branch together: branch target must never be fetched
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hbfc0_0200, 1'b1, 32'hbfc0_0380, a);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a);
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a);
        end
        check32("exbr_first", acc_q[1], 32'h1fc0_0380);
        check32("exbr_second", acc_q[2], 32'h1fc0_0384);
        found = 0;
        foreach (acc_q[k]) if (acc_q[k] == 32'h1fc0_0200) found++;
        check32("exbr_no_target", found, 32'd0);

`ifdef INST_FETCH_ADDR_CHECK_EN
        // Misaligned exception vector becomes a faulting fetch without a bus read
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, a);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hbfc0_0382, a);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, a);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, a);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, a);
        check1("ac_no_read", ibus_read, 1'b0);
        check1("ac_valid", pipe_if.valid, 1'b1);
        check1("ac_iaddr_ex", pipe_if.iaddr_ex, 1'b1);
        check32("ac_vaddr", pipe_if.mmu_iaddr_resp[0].vaddr, 32'hbfc0_0382);
        check32("ac_bus_count", acc_q.size(), 32'd1);
`endif

        // Randomized traffic against the model, including PC wrap past 2^32
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic ok, iv, rdy, brv, exv;
            logic [31:0] brt;
            ok  = ($urandom % 2) == 0;
            rdy = ($urandom % 10) < 7;
            iv  = bus_busy && (bus_cnt == 0);
            exv = ($urandom % 40) == 0;
            brv = !m_pend && (($urandom % 12) == 0);
            brt = 32'hbfc0_0000 + {$urandom_range(0, 255), 2'b00};
            if (($urandom % 4) == 0) vec = 32'hffff_fff8;
            else vec = 32'hbfc0_0000 + {$urandom_range(0, 255), 2'b00};
            step(ok, iv, rdy, brv, brt, exv, vec, a);
            if (iv) bus_busy = 1'b0;
            else if (bus_busy) bus_cnt--;
            if (a) begin
                bus_busy = 1'b1;
                bus_cnt  = $urandom_range(0, 2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
